// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state, owner and access-size codes for the memory port arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA} state_t;
    typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/mem_wstrb_gen.sv
// mem_wstrb_gen: byte-lane strobes and lane-replicated write data from access size and address.
module mem_wstrb_gen
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_wdata
);
    logic [3:0] mask;
    // Size 3 falls through to the word case.
    always_comb begin
        mask = size == SZ_BYTE ? 4'b0001 << addr :
               size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wstrb = wr ? mask : 4'b0000;
        lane_wdata = size == SZ_BYTE ? {4{wdata[7:0]}} :
                     size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like bus between the fetch and load/store ports, one transaction at a time.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              inst_stall,
    output logic              data_stall
);
    state_t state;
    owner_t owner, last_grant;
    logic inst_busy, data_busy, addr_hs, data_hs, pick_data;
    logic [3:0] gen_wstrb;
    logic [DATA_W-1:0] gen_wdata;

    mem_wstrb_gen u_wstrb (
        .size(data_size), .addr(data_addr[1:0]), .wr(data_wr), .wdata(data_wdata),
        .wstrb(gen_wstrb), .lane_wdata(gen_wdata)
    );

    // Handshakes only count in the state that expects them; stray pulses are dropped.
    assign addr_hs      = state == WAIT_ADDR && bus_addr_ok;
    assign data_hs      = state == WAIT_DATA && bus_data_ok;
    assign inst_addr_ok = addr_hs && owner == OWN_INST;
    assign data_addr_ok = addr_hs && owner == OWN_DATA;
    assign inst_data_ok = data_hs && owner == OWN_INST;
    assign data_data_ok = data_hs && owner == OWN_DATA;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;
    assign pick_data    = data_req && (!inst_req || last_grant == OWN_INST);
    assign inst_stall   = resetn && (inst_req || inst_busy) && !inst_data_ok;
    assign data_stall   = resetn && (data_req || data_busy) && !data_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            last_grant <= OWN_INST;
            inst_busy  <= 1'b0;
            data_busy  <= 1'b0;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_size   <= '0;
            bus_addr   <= '0;
            bus_wstrb  <= '0;
            bus_wdata  <= '0;
        end else begin
            inst_busy <= inst_addr_ok || (inst_busy && !inst_data_ok);
            data_busy <= data_addr_ok || (data_busy && !data_data_ok);
            case (state)
                IDLE: if (inst_req || data_req) begin
                    state      <= WAIT_ADDR;
                    bus_req    <= 1'b1;
                    owner      <= pick_data ? OWN_DATA : OWN_INST;
                    last_grant <= pick_data ? OWN_DATA : OWN_INST;
                    bus_wr     <= pick_data && data_wr;
                    bus_size   <= pick_data ? data_size : SZ_WORD;
                    bus_addr   <= pick_data ? data_addr : inst_addr;
                    bus_wstrb  <= pick_data ? gen_wstrb : 4'b0000;
                    bus_wdata  <= pick_data ? gen_wdata : '0;
                end
                WAIT_ADDR: if (bus_addr_ok) begin
                    state   <= WAIT_DATA;
                    bus_req <= 1'b0;
                end
                WAIT_DATA: if (bus_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario bench for the fetch / load-store bus arbiter.
module tb_mem_port_arbiter;
    logic clk = 1'b0, resetn = 1'b0;
    logic inst_req = 1'b0, data_req = 1'b0, data_wr = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0, bus_rdata = '0;
    logic [1:0] data_size = '0;
    logic bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic bus_req, bus_wr, inst_stall, data_stall;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic [1:0] bus_size;
    logic [3:0] bus_wstrb;
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .inst_stall(inst_stall), .data_stall(data_stall)
    );

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Called at a negedge; returns at negedge+1 with bus_req high or a counted timeout.
    task automatic wait_bus_req(input string tag);
        int n = 0;
        #1;
        while (bus_req !== 1'b1 && n < 8) begin
            @(negedge clk); #1; n++;
        end
        vectors++;
        if (n >= 8) begin miscompares++; $display("FAIL %s bus_req timeout: got %b expected 1", tag, bus_req); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; inst_req = 1'b1; data_req = 1'b1; bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL rst bus_req: got %b expected 0", bus_req); end
        vectors++; if (bus_wstrb !== 4'h0) begin miscompares++; $display("FAIL rst bus_wstrb: got %b expected 0000", bus_wstrb); end
        vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("FAIL rst bus_addr: got %h expected 0", bus_addr); end
        vectors++; if ({inst_stall, data_stall} !== 2'b00) begin miscompares++; $display("FAIL rst stalls: got %b expected 00", {inst_stall, data_stall}); end
        vectors++; if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 4'h0) begin
            miscompares++; $display("FAIL rst handshakes: got %b expected 0000", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}); end
        @(negedge clk);
        inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("FAIL fetch c0 bus_req: got %b expected 0", bus_req); end
        vectors++; if (inst_stall !== 1'b1) begin miscompares++; $display("FAIL fetch c0 inst_stall: got %b expected 1", inst_stall); end
        @(negedge clk); #1;
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("FAIL fetch c1 bus_req: got %b expected 1", bus_req); end
        vectors++; if (bus_addr !== 32'hBFC0_0000) begin miscompares++; $display("FAIL fetch c1 bus_addr: got %h expected bfc00000", bus_addr); end
        vectors++; if ({bus_wr, bus_size, bus_wstrb} !== 7'b0_10_0000) begin
            miscompares++; $display("FAIL fetch c1 wr/size/wstrb: got %b expected 0100000", {bus_wr, bus_size, bus_wstrb}); end
        @(negedge clk);
        bus_addr_ok = 1'b1;
        #1;
        vectors++; if ({inst_addr_ok, data_addr_ok, bus_req} !== 3'b101) begin
            miscompares++; $display("FAIL fetch c2 addr_ok: got %b expected 101", {inst_addr_ok, data_addr_ok, bus_req}); end
        @(negedge clk);
        bus_addr_ok = 1'b0; inst_req = 1'b0;
        #1;
        vectors++; if ({bus_req, inst_stall} !== 2'b01) begin miscompares++; $display("FAIL fetch c3 req/stall: got %b expected 01", {bus_req, inst_stall}); end
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h2408_0001;
        #1;
        vectors++; if (inst_data_ok !== 1'b1) begin miscompares++; $display("FAIL fetch c4 inst_data_ok: got %b expected 1", inst_data_ok); end
        vectors++; if (inst_rdata !== 32'h2408_0001) begin miscompares++; $display("FAIL fetch c4 inst_rdata: got %h expected 24080001", inst_rdata); end
        vectors++; if (data_rdata !== 32'h0) begin miscompares++; $display("FAIL fetch c4 data_rdata: got %h expected 0", data_rdata); end
        vectors++; if (inst_stall !== 1'b0) begin miscompares++; $display("FAIL fetch c4 inst_stall: got %b expected 0", inst_stall); end
        @(negedge clk);
        bus_rdata = 32'hFFFF_FFFF;
        #1;
        vectors++; if ({inst_data_ok, inst_stall, bus_req} !== 3'b000) begin
            miscompares++; $display("FAIL fetch c5 idle spurious data_ok: got %b expected 000", {inst_data_ok, inst_stall, bus_req}); end
        vectors++; if (inst_rdata !== 32'h0) begin miscompares++; $display("FAIL fetch c5 inst_rdata: got %h expected 0", inst_rdata); end
        @(negedge clk);
        bus_data_ok = 1'b0;
    endtask

    task automatic test_alternate();
        logic exp_d;
        do_reset();
        inst_req = 1'b1; inst_addr = 32'h0000_2000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            exp_d = (k % 2) == 0;
            wait_bus_req($sformatf("alt%0d", k));
            vectors++; if (bus_addr !== (exp_d ? 32'h1000 : 32'h2000)) begin
                miscompares++; $display("FAIL alt%0d bus_addr: got %h expected %h", k, bus_addr, exp_d ? 32'h1000 : 32'h2000); end
            bus_addr_ok = 1'b1;
            #1;
            vectors++; if ({data_addr_ok, inst_addr_ok} !== {exp_d, !exp_d}) begin
                miscompares++; $display("FAIL alt%0d addr_ok d/i: got %b expected %b", k, {data_addr_ok, inst_addr_ok}, {exp_d, !exp_d}); end
            @(negedge clk);
            bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h100 + k;
            #1;
            vectors++; if ({data_data_ok, inst_data_ok} !== {exp_d, !exp_d}) begin
                miscompares++; $display("FAIL alt%0d data_ok d/i: got %b expected %b", k, {data_data_ok, inst_data_ok}, {exp_d, !exp_d}); end
            vectors++; if ((exp_d ? data_rdata : inst_rdata) !== 32'h100 + k) begin
                miscompares++; $display("FAIL alt%0d rdata: got %h expected %h", k, exp_d ? data_rdata : inst_rdata, 32'h100 + k); end
            @(negedge clk);
            bus_data_ok = 1'b0;
        end
        inst_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_strobe();
        logic [1:0]  sz [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [31:0] ad [4] = '{32'h0000_0103, 32'h0000_0102, 32'h0000_0100, 32'h0000_0101};
        logic [31:0] wd [4] = '{32'h0000_00AB, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0123_4567};
        logic [3:0]  es [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b1111};
        logic [31:0] ew [4] = '{32'hABAB_ABAB, 32'h1234_1234, 32'hDEAD_BEEF, 32'h0123_4567};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            data_req = 1'b1; data_wr = 1'b1; data_size = sz[i]; data_addr = ad[i]; data_wdata = wd[i];
            wait_bus_req($sformatf("strb%0d", i));
            vectors++; if (bus_wstrb !== es[i]) begin miscompares++; $display("FAIL strb%0d wstrb: got %b expected %b", i, bus_wstrb, es[i]); end
            vectors++; if (bus_wdata !== ew[i]) begin miscompares++; $display("FAIL strb%0d wdata: got %h expected %h", i, bus_wdata, ew[i]); end
            vectors++; if ({bus_wr, bus_size} !== {1'b1, sz[i]}) begin
                miscompares++; $display("FAIL strb%0d wr/size: got %b expected %b", i, {bus_wr, bus_size}, {1'b1, sz[i]}); end
            bus_addr_ok = 1'b1;
            @(negedge clk);
            bus_addr_ok = 1'b0; data_req = 1'b0; bus_data_ok = 1'b1;
            #1;
            vectors++; if (data_data_ok !== 1'b1) begin miscompares++; $display("FAIL strb%0d data_ok: got %b expected 1", i, data_data_ok); end
            @(negedge clk);
            bus_data_ok = 1'b0;
        end
    endtask

    task automatic test_slow_bus();
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_3000;
        wait_bus_req("slow");
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({bus_req, bus_addr, bus_size, bus_wr} !== {1'b1, 32'h3000, 2'd2, 1'b0}) begin
                miscompares++; $display("FAIL slow wait_addr%0d fields: got %b %h %b %b", i, bus_req, bus_addr, bus_size, bus_wr); end
            vectors++; if (data_stall !== 1'b1) begin miscompares++; $display("FAIL slow wait_addr%0d stall: got %b expected 1", i, data_stall); end
            @(negedge clk); #1;
        end
        bus_addr_ok = 1'b1;
        #1;
        vectors++; if ({data_addr_ok, data_stall} !== 2'b11) begin
            miscompares++; $display("FAIL slow addr_ok/stall: got %b expected 11", {data_addr_ok, data_stall}); end
        @(negedge clk);
        bus_addr_ok = 1'b0; data_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_addr_ok = i == 2;
            #1;
            vectors++; if ({data_stall, bus_req, data_data_ok, data_addr_ok} !== 4'b1000) begin
                miscompares++; $display("FAIL slow wait_data%0d stall/req/dok/aok: got %b expected 1000", i, {data_stall, bus_req, data_data_ok, data_addr_ok}); end
            @(negedge clk);
        end
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        vectors++; if ({data_data_ok, data_stall} !== 2'b10) begin
            miscompares++; $display("FAIL slow data_ok/stall: got %b expected 10", {data_data_ok, data_stall}); end
        vectors++; if (data_rdata !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL slow data_rdata: got %h expected cafef00d", data_rdata); end
        @(negedge clk);
        bus_data_ok = 1'b0;
        #1;
        vectors++; if (data_stall !== 1'b0) begin miscompares++; $display("FAIL slow after stall: got %b expected 0", data_stall); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h0000_4001; data_wdata = 32'h55;
        wait_bus_req("rmid");
        vectors++; if (bus_wstrb !== 4'b0010) begin miscompares++; $display("FAIL rmid wstrb: got %b expected 0010", bus_wstrb); end
        bus_addr_ok = 1'b1;
        @(negedge clk);
        bus_addr_ok = 1'b0; data_req = 1'b0;
        #1;
        vectors++; if ({bus_req, data_stall} !== 2'b01) begin miscompares++; $display("FAIL rmid wait_data req/stall: got %b expected 01", {bus_req, data_stall}); end
        resetn = 1'b0;
        #1;
        vectors++; if ({bus_req, bus_wr, bus_wstrb, data_stall, inst_stall} !== 8'h00) begin
            miscompares++; $display("FAIL rmid in reset req/wr/wstrb/stalls: got %b expected 0", {bus_req, bus_wr, bus_wstrb, data_stall, inst_stall}); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus_data_ok = 1'b1; bus_rdata = 32'h7777_7777;
        #1;
        vectors++; if ({data_data_ok, inst_data_ok, data_stall, bus_req} !== 4'b0000) begin
            miscompares++; $display("FAIL rmid late data_ok: got %b expected 0000", {data_data_ok, inst_data_ok, data_stall, bus_req}); end
        vectors++; if (data_rdata !== 32'h0) begin miscompares++; $display("FAIL rmid data_rdata: got %h expected 0", data_rdata); end
        @(negedge clk);
        bus_data_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_alternate();
        test_strobe();
        test_slow_bus();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
